win3x3_gen: RTL
===============

# win3x3_gen

Streaming 3x3 window generator sitting directly upstream of the Gaussian blur kernel. Accepts one raster-order pixel per cycle, keeps the two previous image rows in on-chip line buffers, and presents a complete 3x3 neighbourhood per output beat: 9 pixels, flattened. Only interior windows are emitted, i.e. windows whose 3x3 footprint lies fully inside the frame. Valid/ready handshakes on both sides provide backpressure from the blur stage.

## Interface
- IMG_WIDTH, 640: pixels per row; ≥ 3.
- IMG_HEIGHT, 480: rows per frame; ≥ 3.
- DATA_W, 8: bits per pixel.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  in_pixel valid.
- in_ready  out  1  block can accept in_pixel this cycle.
- in_pixel  in  DATA_W  raster-order pixel, row-major, frame starts at (0,0).
- out_valid  out  1  out_win holds a valid window.
- out_ready  in  1  downstream accepts out_win this cycle.
- out_win  out  9*DATA_W  window; pixel (r,c), r,c∈0..2, at bits [(3r+c)*DATA_W +: DATA_W]; (0,0) = top-left = image (row-2, col-2); (2,2) = current pixel.

## Operation
- Accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) give the position of the next accepted pixel.
  - On accept: col+1; at IMG_WIDTH-1, col→0 and row+1.
  - row at IMG_HEIGHT-1 with col wrap → row 0, which starts the next frame.
- Line buffers lb0 (row-1) and lb1 (row-2), each IMG_WIDTH×DATA_W.
  - On accept at col: read t=lb1[col], m=lb0[col].
  - Write lb0[col]←in_pixel and lb1[col]←m in the same cycle.
- Window registers: 3 columns × 3 rows. On accept, shift left one column and load {t, m, in_pixel} (rows 0,1,2) into column 2.
- Window is valid when the accepted pixel has row≥2 and col≥2. Otherwise the shift still occurs, but out_valid is not set.
- Per frame: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) output windows. Windows straddling a row wrap are never emitted.
- Single output register stage; in_ready = !out_valid || out_ready.
  - Output register loads on an accept of a valid-window pixel.
  - out_valid clears on a transfer with no new valid-window accept.
  - Transfer and new valid-window accept in the same cycle: register reloads, out_valid stays 1.
- Line buffer contents are not reset and not cleared between frames. Stale data is never exposed because row<2 suppresses output.
- Arithmetic: counters are $clog2 of their range; pure data movement, no arithmetic on pixels.

## Timing
- Reset values: in_ready 1, out_valid 0, out_win 0, col 0, row 0, window registers 0.
- Latency: 1 cycle, from accept of pixel (r,c) with r,c≥2 to out_valid=1 carrying its window.
- Throughput: 1 window/cycle while out_ready held high; no bubbles at row or frame boundaries.
- Stall: while out_valid && !out_ready, out_win stable, in_ready=0, counters frozen.
- in_valid low: counters and window frozen; a pending output stays until transferred.
- Reset mid-frame: asynchronous. Pending output is dropped. The next accepted pixel is treated as (0,0) of a new frame; the first window appears after pixel (2,2).

## Configuration
- WIN3X3_MARKERS_EN defined: adds outputs out_sof (1 bit) and out_eol (1 bit), registered alongside out_win.
  - out_sof=1 on the first window of a frame (accepted pixel (2,2)).
  - out_eol=1 on the last window of each row (accepted pixel col=IMG_WIDTH-1).
  - Both reset to 0 and are qualified by out_valid.
- Not defined: ports absent, no marker logic. All other behaviour identical.

## Test plan
All scenarios use IMG_WIDTH=5, IMG_HEIGHT=4, DATA_W=8, and pixel value = row*16+col.
- Continuous stream, out_ready=1: exactly 6 windows.
  - First window one cycle after accepting 0x22: win(0,0)=0x00, win(1,1)=0x11, win(2,2)=0x22.
  - Last window: win(0,0)=0x12, win(2,2)=0x34.
- Two back-to-back frames: second frame yields 6 windows identical to the first. No window is emitted for frame-2 pixels at rows 0–1.
- out_ready=0 for 4 cycles on the window ending at 0x23: out_win held, in_ready=0, and no window lost or duplicated over the frame (count = 6).
- Random in_valid gaps plus random out_ready: window sequence matches a golden model; total 6 windows per frame.
- Assert rst after pixel 0x21 is accepted, then restart the frame: no output before 0x22 of the new frame; out_valid=0 and out_win=0 during reset.
- With WIN3X3_MARKERS_EN defined:
  - out_sof=1 only on the window centred at 0x11.
  - out_eol=1 on windows ending at 0x24 and 0x34.

Source files
------------

// File: rtl/win3x3_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift window,
// emitting only interior windows. Optional WIN3X3_MARKERS_EN adds out_sof/out_eol.
module win3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_pixel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [9*DATA_W-1:0]   out_win
`ifdef WIN3X3_MARKERS_EN
  ,
  output logic                  out_sof,
  output logic                  out_eol
`endif
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  // Handshake: a beat moves when valid && ready on that side. in_ready only
  // drops while an output is held and the consumer is not taking it.

  logic [COL_W-1:0]              col_q, col_d;
  logic [ROW_W-1:0]              row_q, row_d;
  logic [8:0][DATA_W-1:0]        win_q, win_d;
  logic [9*DATA_W-1:0]           out_win_q, out_win_d;
  logic                          out_valid_q, out_valid_d;
  logic [DATA_W-1:0]             lb0_mem [IMG_WIDTH];
  logic [DATA_W-1:0]             lb1_mem [IMG_WIDTH];
  logic [DATA_W-1:0]             tap_top, tap_mid;
  logic                          accept, win_ok, col_last;

  always_comb begin
    in_ready    = !out_valid_q || out_ready;
    accept      = in_valid && in_ready;
    tap_top     = lb1_mem[col_q];
    tap_mid     = lb0_mem[col_q];
    col_last    = (col_q == COL_W'(IMG_WIDTH - 1));
    win_ok      = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    out_win_d   = out_win_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      // Column 2 takes {row-2, row-1, current}; older columns slide left.
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = tap_top;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = tap_mid;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = in_pixel;
    end
    if (accept && win_ok) begin
      out_win_d   = win_d;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      out_win_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      out_win_q   <= out_win_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Line buffers hold no reset; rows 0-1 never emit, so stale data stays hidden.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_mem[col_q] <= in_pixel;
      lb1_mem[col_q] <= tap_mid;
    end
  end

  assign out_valid = out_valid_q;
  assign out_win   = out_win_q;

`ifdef WIN3X3_MARKERS_EN
  logic sof_q, sof_d, eol_q, eol_d;

  always_comb begin
    sof_d = sof_q;
    eol_d = eol_q;
    if (accept && win_ok) begin
      sof_d = (row_q == ROW_W'(2)) && (col_q == COL_W'(2));
      eol_d = col_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sof_q <= 1'b0;
      eol_q <= 1'b0;
    end else begin
      sof_q <= sof_d;
      eol_q <= eol_d;
    end
  end

  assign out_sof = sof_q;
  assign out_eol = eol_q;
`endif

endmodule
